// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file, x0 hardwired to zero; optional macro REGFILE_WRITE_BYPASS_EN gives write-first reads.
// Latency: writes commit on the rising Clk edge, reads are combinational (0 cycles).
// Backpressure: none, a write is accepted every cycle Reg_Write is high and Reset_n is high.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] RS1_Addr,
    input  logic [ADDR_W-1:0] RS2_Addr,
    input  logic [ADDR_W-1:0] RD_Addr,
    input  logic [DATA_W-1:0] WData,
    input  logic              Reg_Write,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] RS1_Data,
    output logic [DATA_W-1:0] RS2_Data,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic [15:0]       Write_Count
);
    localparam int DEPTH = 2 ** ADDR_W;

    // x0 has no storage; index 0 is decoded to zero on every read port
    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic              wr_commit;
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];

    assign wr_commit = Reg_Write && (RD_Addr != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            regs[RD_Addr] <= WData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Write_Count <= '0;
        end else if (wr_commit && (Write_Count != 16'hFFFF)) begin
            Write_Count <= Write_Count + 16'd1;
        end
    end

    assign rd_addr[0] = RS1_Addr;
    assign rd_addr[1] = RS2_Addr;
    assign rd_addr[2] = Dbg_Addr;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (rd_addr[p] != '0) begin
                rd_data[p] = regs[rd_addr[p]];
            end
`ifdef REGFILE_WRITE_BYPASS_EN
            // Reset_n gating keeps a write presented during reset from leaking out
            if (Reset_n && wr_commit && (rd_addr[p] == RD_Addr)) begin
                rd_data[p] = WData;
            end
`endif
        end
    end

    assign RS1_Data = rd_data[0];
    assign RS2_Data = rd_data[1];
    assign Dbg_Data = rd_data[2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default and REGFILE_WRITE_BYPASS_EN builds).
module tb_register_file;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  RS1_Addr, RS2_Addr, RD_Addr, Dbg_Addr;
    logic [31:0] WData;
    logic        Reg_Write;
    logic [31:0] RS1_Data, RS2_Data, Dbg_Data;
    logic [15:0] Write_Count;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .RS1_Addr(RS1_Addr), .RS2_Addr(RS2_Addr), .RD_Addr(RD_Addr),
        .WData(WData), .Reg_Write(Reg_Write), .Dbg_Addr(Dbg_Addr),
        .RS1_Data(RS1_Data), .RS2_Data(RS2_Data), .Dbg_Data(Dbg_Data),
        .Write_Count(Write_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present a write at the falling edge, let it commit, then drop the enable
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        RD_Addr = a; WData = d; Reg_Write = 1'b1;
        @(posedge Clk);
        #1 Reg_Write = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; Reg_Write = 1'b0; WData = '0;
        RS1_Addr = '0; RS2_Addr = '0; RD_Addr = '0; Dbg_Addr = '0;
        #3;
        check("reset_rs1", RS1_Data, 32'h0);
        check("reset_rs2", RS2_Data, 32'h0);
        check("reset_dbg", Dbg_Data, 32'h0);
        check("reset_cnt", {16'h0, Write_Count}, 32'h0);

        // Write attempted while reset is held must be ignored, bypass included
        @(negedge Clk);
        RD_Addr = 5'd5; WData = 32'hDEADBEEF; Reg_Write = 1'b1; RS1_Addr = 5'd5;
        #1 check("rst_wr_bypass", RS1_Data, 32'h0);
        @(posedge Clk); #1;
        check("rst_wr_x5", RS1_Data, 32'h0);
        check("rst_wr_cnt", {16'h0, Write_Count}, 32'h0);
        Reg_Write = 1'b0;
        @(negedge Clk) Reset_n = 1'b1;
        #1 check("post_rst_x5", RS1_Data, 32'h0);

        wr(5'd1, 32'h12345678);
        wr(5'd31, 32'hFFFFFFFF);
        RS1_Addr = 5'd1; RS2_Addr = 5'd31; Dbg_Addr = 5'd31;
        #1;
        check("rd_x1", RS1_Data, 32'h12345678);
        check("rd_x31", RS2_Data, 32'hFFFFFFFF);
        check("dbg_x31", Dbg_Data, 32'hFFFFFFFF);
        check("cnt_2", {16'h0, Write_Count}, 32'd2);

        wr(5'd0, 32'hAAAAAAAA);
        RS1_Addr = 5'd0;
        #1;
        check("x0_zero", RS1_Data, 32'h0);
        check("x0_cnt", {16'h0, Write_Count}, 32'd2);

        // Same-cycle read/write hazard on x7
        wr(5'd7, 32'h1);
        @(negedge Clk);
        RD_Addr = 5'd7; WData = 32'h2; Reg_Write = 1'b1; RS2_Addr = 5'd7; Dbg_Addr = 5'd7;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("hazard_pre_rs2", RS2_Data, 32'h2);
        check("hazard_pre_dbg", Dbg_Data, 32'h2);
`else
        check("hazard_pre_rs2", RS2_Data, 32'h1);
        check("hazard_pre_dbg", Dbg_Data, 32'h1);
`endif
        @(posedge Clk); #1 Reg_Write = 1'b0;
        check("hazard_post_rs2", RS2_Data, 32'h2);
        check("hazard_cnt", {16'h0, Write_Count}, 32'd4);

        // Back-to-back writes to one index: last wins, both count
        @(negedge Clk);
        RD_Addr = 5'd9; WData = 32'h0000000A; Reg_Write = 1'b1;
        @(negedge Clk);
        WData = 32'h0000000B;
        @(posedge Clk); #1 Reg_Write = 1'b0;
        RS1_Addr = 5'd9;
        #1;
        check("b2b_x9", RS1_Data, 32'hB);
        check("b2b_cnt", {16'h0, Write_Count}, 32'd6);

        for (int i = 1; i < 32; i++) wr(i[4:0], 32'(i));
        for (int i = 0; i < 32; i++) begin
            Dbg_Addr = i[4:0];
            #1 check($sformatf("fill_x%0d", i), Dbg_Data, 32'(i));
        end
        check("fill_cnt", {16'h0, Write_Count}, 32'd37);

        // Async reset between clock edges clears everything at once
        RS1_Addr = 5'd1; RS2_Addr = 5'd31; Dbg_Addr = 5'd17;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rs1", RS1_Data, 32'h0);
        check("async_rs2", RS2_Data, 32'h0);
        check("async_dbg", Dbg_Data, 32'h0);
        check("async_cnt", {16'h0, Write_Count}, 32'h0);
        @(negedge Clk) Reset_n = 1'b1;

        // Saturation: 65537 commits to x3 with WData = 0..65536
        @(negedge Clk);
        RD_Addr = 5'd3; WData = 32'd0; Reg_Write = 1'b1; RS1_Addr = 5'd3;
        for (int i = 1; i <= 65536; i++) begin
            @(negedge Clk);
            WData = 32'(i);
            if (i == 65534) check("cnt_fffe", {16'h0, Write_Count}, 32'h0000FFFE);
            if (i == 65535) check("cnt_ffff", {16'h0, Write_Count}, 32'h0000FFFF);
        end
        @(posedge Clk); #1 Reg_Write = 1'b0;
        #1;
        check("sat_cnt", {16'h0, Write_Count}, 32'h0000FFFF);
        check("sat_x3", RS1_Data, 32'h00010000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

32 x 32-bit integer register file for the single-cycle RISC-V core, sitting directly downstream of the write-data select mux. It consumes the selected write-back word and the destination index, commits it on the rising clock edge, and serves two combinational source-operand reads to the ALU/immediate path plus one debug read port. Register x0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth is 2^ADDR_W = 32 entries.

Ports:
- Clk  input  1  core clock; all writes commit on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset; clears every register to 0.
- RS1_Addr  input  ADDR_W  source register 1 index.
- RS2_Addr  input  ADDR_W  source register 2 index.
- RD_Addr  input  ADDR_W  destination register index.
- WData  input  DATA_W  write-back word from the write-data mux.
- Reg_Write  input  1  write enable for RD_Addr.
- Dbg_Addr  input  ADDR_W  debug/bench read index.
- RS1_Data  output  DATA_W  contents of RS1_Addr.
- RS2_Data  output  DATA_W  contents of RS2_Addr.
- Dbg_Data  output  DATA_W  contents of Dbg_Addr.
- Write_Count  output  16  number of committed non-x0 writes since reset; saturates at 16'hFFFF.

## Operation
- Storage: 31 physical registers, x1..x31. x0 has no storage, and any read of index 0 returns 0.
- Write: on rising Clk with Reset_n high, Reg_Write = 1 and RD_Addr != 0, set reg[RD_Addr] <= WData.
- A write to x0 is silently discarded and does not increment Write_Count.
- Reg_Write = 0 leaves all state unchanged.
- Reads: RS1_Data, RS2_Data and Dbg_Data are combinational from current register contents (asynchronous read).
- Any port may address the same register as any other port; there are no conflicts between read ports.
- Write_Count increments by 1 on each committed write and holds at 16'hFFFF once reached.
- Reset: while Reset_n = 0, all registers and Write_Count are 0.
  - Consequently RS1_Data, RS2_Data and Dbg_Data read 0 for every index.
  - Writes presented during reset are ignored.
  - Reset asserted mid-cycle clears state immediately, without waiting for a Clk edge.
  - Release is synchronous-safe: the first write can commit on the first rising edge after Reset_n rises.

## Timing
- Write latency: 1 cycle. Data presented in cycle N is visible on the read ports from just after the rising edge that ends cycle N.
- Read latency: 0 cycles (combinational), settling within the same cycle as the address change.
- Simultaneous read and write of the same non-zero index in one cycle:
  - without bypass, the read returns the old value for the whole cycle and the new value after the edge;
  - with bypass, see Configuration.
- Back-to-back writes to the same index on consecutive edges each commit; the last one wins.
- Reset values of outputs: RS1_Data = RS2_Data = Dbg_Data = 32'h0 and Write_Count = 16'h0.

## Configuration
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: when Reg_Write = 1, RD_Addr != 0 and a read address equals RD_Addr, that read port returns WData combinationally in the same cycle (write-first).
  - Applies to RS1, RS2 and Dbg ports.
  - Never applies during reset or to x0.
- Undefined: read ports return stored contents only (read-first). All other behaviour is identical.

## Test plan
- Reset: hold Reset_n = 0, write x5 = 32'hDEADBEEF -> RS1_Data reads 0 for x5 and Write_Count = 0. After release, x5 still reads 0.
- Basic write/read: write x1 = 32'h12345678, then x31 = 32'hFFFFFFFF -> RS1 = x1 and RS2 = x31 read those values, and Write_Count = 2.
- x0 discard: write x0 = 32'hAAAAAAAA -> RS1_Addr = 0 reads 0 and Write_Count is unchanged.
- Same-cycle hazard: x7 holds 32'h1, write x7 = 32'h2 while RS2_Addr = 7.
  - Without the macro, RS2_Data = 1 before the edge and 2 after.
  - With the macro, RS2_Data = 2 in the same cycle.
- Async reset mid-operation: fill x1..x31 with their index, assert Reset_n low between clock edges -> all read ports show 0 immediately and Write_Count = 0.
- Saturation: commit 65537 writes to x3 -> Write_Count = 16'hFFFF, and x3 holds the final WData.
